// File: rtl/midi_out.sv
// midi_out: MIDI 8N1 transmitter fed by a whole-message FIFO, one bit per baud_clk.
// Define MIDI_RUNNING_STATUS_EN to omit repeated channel status bytes (running status).
module midi_out #(
    parameter int FIFO_DEPTH = 4,
    parameter int IDLE_GAP   = 2
) (
    input  logic       baud_clk,
    input  logic       rst,
    input  logic       send,
    output logic       ready,
    input  logic [7:0] status_out,
    input  logic [7:0] data1_out,
    input  logic [7:0] data2_out,
    input  logic [1:0] bytes_cnt_out,
    output logic       midi_tx,
    output logic       busy,
    output logic       done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = IDLE_GAP > 1 ? $clog2(IDLE_GAP) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

    logic [25:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, empty, omit;
    logic [7:0]    q_status, q_data1, q_data2, d1m, d2m;
    logic [1:0]    q_cnt;

    state_t        state;
    logic [7:0]    shift, nxt1, nxt2;
    logic [1:0]    remain;
    logic [2:0]    bit_cnt;
    logic [GW-1:0] gap_cnt;

    assign ready = count != (AW+1)'(FIFO_DEPTH);
    assign empty = count == '0;
    assign push  = send && ready && bytes_cnt_out != 2'd0;
    assign pop   = state == IDLE && !empty;
    assign {q_status, q_data1, q_data2, q_cnt} = mem[rd_ptr];
    assign d1m = {1'b0, q_data1[6:0]};
    assign d2m = {1'b0, q_data2[6:0]};

    always_ff @(posedge baud_clk) begin
        if (push)
            mem[wr_ptr] <= {status_out, data1_out, data2_out, bytes_cnt_out};
    end

    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] last_status;
    logic       chan;
    assign chan = q_status >= 8'h80 && q_status <= 8'hEF;
    assign omit = chan && q_cnt >= 2'd2 && q_status == last_status;
    // System common clears running status; realtime leaves it untouched.
    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst)
            last_status <= '0;
        else if (pop && chan)
            last_status <= q_status;
        else if (pop && q_status[7:3] == 5'b11110)
            last_status <= '0;
    end
`else
    assign omit = 1'b0;
`endif

    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            midi_tx <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            shift   <= '0;
            nxt1    <= '0;
            nxt2    <= '0;
            remain  <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (pop) begin
                    shift   <= omit ? d1m : q_status;
                    nxt1    <= omit ? d2m : d1m;
                    nxt2    <= d2m;
                    remain  <= omit ? q_cnt - 2'd2 : q_cnt - 2'd1;
                    midi_tx <= 1'b0;
                    busy    <= 1'b1;
                    state   <= START;
                end
                START: begin
                    midi_tx <= shift[0];
                    shift   <= shift >> 1;
                    bit_cnt <= '0;
                    state   <= DATA;
                end
                DATA: if (bit_cnt == 3'd7) begin
                    midi_tx <= 1'b1;
                    state   <= STOP;
                end else begin
                    midi_tx <= shift[0];
                    shift   <= shift >> 1;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                // Next byte of the same message starts straight after the stop bit.
                STOP: if (remain != 2'd0) begin
                    shift   <= nxt1;
                    nxt1    <= nxt2;
                    remain  <= remain - 2'd1;
                    midi_tx <= 1'b0;
                    state   <= START;
                end else begin
                    done    <= 1'b1;
                    gap_cnt <= '0;
                    if (IDLE_GAP > 0)
                        state <= GAP;
                    else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                GAP: if (gap_cnt == GW'(IDLE_GAP - 1)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else
                    gap_cnt <= gap_cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_midi_out.sv
// tb_midi_out: scoreboard bench for midi_out; expected bytes follow
// MIDI_RUNNING_STATUS_EN when the build defines it.
`timescale 1ns/1ps
module tb_midi_out;
    localparam int DEPTH = 4;
    localparam int GAP   = 2;
    localparam int LIMIT = 2000;

    logic       baud_clk = 1'b0, rst = 1'b1, send = 1'b0;
    logic       ready, midi_tx, busy, done;
    logic [7:0] status_out = '0, data1_out = '0, data2_out = '0;
    logic [1:0] bytes_cnt_out = '0;

    int         errors = 0, checks = 0;
    logic [7:0] exp_q[$];
    int         gap_q[$];
    bit         track = 1'b0;
    int         mon_bit = -1, hi_run = 0, rx_cnt = 0, done_cnt = 0;
    logic [7:0] mon_byte = '0;
`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] m_last = '0;
`endif

    midi_out #(.FIFO_DEPTH(DEPTH), .IDLE_GAP(GAP)) dut (
        .baud_clk(baud_clk), .rst(rst), .send(send), .ready(ready),
        .status_out(status_out), .data1_out(data1_out), .data2_out(data2_out),
        .bytes_cnt_out(bytes_cnt_out), .midi_tx(midi_tx), .busy(busy), .done(done)
    );

    always #5 baud_clk = ~baud_clk;

    task automatic model(input logic [7:0] s, d1, d2, input logic [1:0] c);
        bit om;
        om = 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
        if (s >= 8'h80 && s <= 8'hEF) begin
            om = c >= 2'd2 && s == m_last;
            m_last = s;
        end else if (s >= 8'hF0 && s <= 8'hF7)
            m_last = '0;
`endif
        if (!om) exp_q.push_back(s);
        if (c >= 2'd2) exp_q.push_back({1'b0, d1[6:0]});
        if (c == 2'd3) exp_q.push_back({1'b0, d2[6:0]});
    endtask

    // UART receiver on the line: decodes frames and pops expected bytes.
    task automatic scoreboard();
        logic [7:0] e;
        forever begin
            @(negedge baud_clk);
            if (done === 1'b1) done_cnt++;
            if (rst) begin
                mon_bit = -1;
                hi_run  = 0;
            end else if (mon_bit < 0) begin
                if (midi_tx === 1'b0) begin
                    if (track) gap_q.push_back(hi_run);
                    mon_bit = 0;
                end else
                    hi_run++;
            end else if (mon_bit < 8) begin
                mon_byte = {midi_tx, mon_byte[7:1]};
                mon_bit++;
            end else begin
                checks++;
                if (midi_tx !== 1'b1) begin
                    errors++;
                    $display("FAIL stop_bit: got %b want 1", midi_tx);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rx_byte: got %h want no byte", mon_byte);
                end else begin
                    e = exp_q.pop_front();
                    if (mon_byte !== e) begin
                        errors++;
                        $display("FAIL rx_byte: got %h want %h", mon_byte, e);
                    end
                end
                rx_cnt++;
                mon_bit = -1;
                hi_run  = 0;
            end
        end
    endtask

    task automatic push(input logic [7:0] s, d1, d2, input logic [1:0] c, output int held);
        status_out = s; data1_out = d1; data2_out = d2; bytes_cnt_out = c; send = 1'b1;
        held = 0;
        while (ready !== 1'b1 && held < LIMIT) begin
            @(negedge baud_clk);
            held++;
        end
        if (held >= LIMIT) begin
            $display("FAIL push_timeout: ready=%b want 1", ready);
            $fatal(1, "push stalled");
        end
        @(negedge baud_clk);
        send = 1'b0;
        model(s, d1, d2, c);
    endtask

    task automatic wait_idle(output bit ok);
        int n;
        n = 0;
        while ((busy !== 1'b0 || mon_bit >= 0 || exp_q.size() != 0) && n < LIMIT) begin
            @(negedge baud_clk);
            n++;
        end
        ok = n < LIMIT;
        repeat (2) @(negedge baud_clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge baud_clk);
        checks++; if (midi_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", midi_tx); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        #2 rst = 1'b0;
        @(negedge baud_clk);
    endtask

    task automatic test_note_on();
        logic [29:0] obs;
        int held, blen, dpos, dn;
        bit ok;
        obs = '0; blen = 0; dpos = -1; dn = 0;
        push(8'h90, 8'h3C, 8'h64, 2'd3, held);
        for (int i = 0; i < 30 + GAP + 6; i++) begin
            @(negedge baud_clk);
            if (i < 30) obs = {obs[28:0], midi_tx};
            if (busy === 1'b1) blen++;
            if (done === 1'b1) begin dn++; dpos = i; end
        end
        checks++; if (obs !== 30'b000001001100011110010001001101) begin errors++; $display("FAIL note_on_wave: got %b want 000001001100011110010001001101", obs); end
        checks++; if (dn != 1 || dpos != 30) begin errors++; $display("FAIL note_on_done: got %0d pulses at %0d want 1 at 30", dn, dpos); end
        checks++; if (blen != 30 + GAP) begin errors++; $display("FAIL note_on_busy: got %0d want %0d", blen, 30 + GAP); end
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL note_on_drain: pending=%0d want 0", exp_q.size()); end
    endtask

    task automatic test_single_byte();
        logic [9:0]  f1;
        logic [19:0] f2;
        int held, d0;
        bit ok;
        d0 = done_cnt; f1 = '0; f2 = '0;
        push(8'hF8, 8'h00, 8'h00, 2'd1, held);
        for (int i = 0; i < 10; i++) begin
            @(negedge baud_clk);
            f1 = {f1[8:0], midi_tx};
        end
        checks++; if (f1 !== 10'b0000111111) begin errors++; $display("FAIL single_wave: got %b want 0000111111", f1); end
        wait_idle(ok);
        push(8'hC0, 8'hFF, 8'h00, 2'd2, held);
        for (int i = 0; i < 20; i++) begin
            @(negedge baud_clk);
            f2 = {f2[18:0], midi_tx};
        end
        checks++; if (f2[9:0] !== 10'b0111111101) begin errors++; $display("FAIL mask_wave: got %b want 0111111101", f2[9:0]); end
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_drain: pending=%0d want 0", exp_q.size()); end
        checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL single_done: got %0d want 2", done_cnt - d0); end
    endtask

    task automatic test_back_to_back();
        int held, ng, nz;
        bit ok;
        ng = 0; nz = 0;
        gap_q.delete();
        track = 1'b1;
        push(8'h90, 8'h3C, 8'h64, 2'd3, held);
        push(8'h80, 8'h3C, 8'h00, 2'd3, held);
        push(8'hC1, 8'h05, 8'h00, 2'd2, held);
        push(8'hF8, 8'h00, 8'h00, 2'd1, held);
        push(8'hB0, 8'h07, 8'h7F, 2'd3, held);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_full: ready=%b want 0", ready); end
        push(8'hFE, 8'h00, 8'h00, 2'd1, held);
        checks++; if (held == 0) begin errors++; $display("FAIL b2b_held: waited %0d want >0", held); end
        wait_idle(ok);
        track = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL b2b_drain: pending=%0d want 0", exp_q.size()); end
        foreach (gap_q[i]) if (i > 0) begin
            if (gap_q[i] == GAP + 1) ng++;
            else if (gap_q[i] == 0) nz++;
        end
        checks++; if (gap_q.size() != 13) begin errors++; $display("FAIL b2b_frames: got %0d want 13", gap_q.size()); end
        checks++; if (ng != 5 || nz != 7) begin errors++; $display("FAIL b2b_gaps: got %0d gaps %0d tight want 5 and 7", ng, nz); end
    endtask

    task automatic test_reset_mid();
        int held, d0, act;
        bit ok;
        act = 0;
        push(8'h90, 8'h3C, 8'h64, 2'd3, held);
        repeat (5) @(negedge baud_clk);
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        checks++; if (midi_tx !== 1'b1) begin errors++; $display("FAIL mid_tx: got %b want 1", midi_tx); end
        checks++; if (busy !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL mid_state: busy=%b ready=%b want 0 1", busy, ready); end
        exp_q.delete();
`ifdef MIDI_RUNNING_STATUS_EN
        m_last = '0;
`endif
        repeat (3) @(negedge baud_clk);
        #2 rst = 1'b0;
        repeat (6) begin
            @(negedge baud_clk);
            if (busy !== 1'b0 || midi_tx !== 1'b1) act++;
        end
        checks++; if (act != 0 || done_cnt != d0) begin errors++; $display("FAIL mid_quiet: activity=%0d done=%0d want 0 0", act, done_cnt - d0); end
        push(8'h90, 8'h3E, 8'h40, 2'd3, held);
        wait_idle(ok);
        checks++; if (!ok || done_cnt != d0 + 1) begin errors++; $display("FAIL mid_after: done=%0d pending=%0d want 1 0", done_cnt - d0, exp_q.size()); end
    endtask

    task automatic test_zero_cnt();
        int d0, r0, act;
        act = 0; d0 = done_cnt; r0 = rx_cnt;
        status_out = 8'h90; data1_out = 8'h3C; data2_out = 8'h64; bytes_cnt_out = 2'd0; send = 1'b1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b want 1", ready); end
        @(negedge baud_clk);
        send = 1'b0;
        repeat (15) begin
            @(negedge baud_clk);
            if (midi_tx !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) act++;
        end
        checks++; if (act != 0) begin errors++; $display("FAIL zero_line: got %0d active cycles want 0", act); end
        checks++; if (done_cnt != d0 || rx_cnt != r0) begin errors++; $display("FAIL zero_done: got %0d done %0d bytes want 0 0", done_cnt - d0, rx_cnt - r0); end
    endtask

    task automatic test_running_status();
        int held, r0, d0, want;
        bit ok;
        @(negedge baud_clk);
        #2 rst = 1'b1;
`ifdef MIDI_RUNNING_STATUS_EN
        m_last = '0;
        want = 14;
`else
        want = 16;
`endif
        @(negedge baud_clk);
        #2 rst = 1'b0;
        @(negedge baud_clk);
        r0 = rx_cnt; d0 = done_cnt;
        push(8'h90, 8'h3C, 8'h64, 2'd3, held);
        push(8'h90, 8'h3E, 8'h64, 2'd3, held);
        push(8'hF8, 8'h00, 8'h00, 2'd1, held);
        push(8'h90, 8'h40, 8'h64, 2'd3, held);
        push(8'hF2, 8'h01, 8'h02, 2'd3, held);
        push(8'h90, 8'h3C, 8'h00, 2'd3, held);
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rs_drain: pending=%0d want 0", exp_q.size()); end
        checks++; if (rx_cnt - r0 != want) begin errors++; $display("FAIL rs_bytes: got %0d want %0d", rx_cnt - r0, want); end
        checks++; if (done_cnt - d0 != 6) begin errors++; $display("FAIL rs_done: got %0d want 6", done_cnt - d0); end
    endtask

    initial begin
        fork
            scoreboard();
        join_none
        test_reset();
        test_note_on();
        test_single_byte();
        test_back_to_back();
        test_reset_mid();
        test_zero_cnt();
        test_running_status();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
